// File: rtl/pmem_pkg.sv
// Shared types and default sizes for the 12-bit microcontroller program memory.
package pmem_pkg;

    localparam int IW_DEF = 12;
    localparam int AW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pmem_ram.sv
// Simple dual-port program RAM: one synchronous write port, one registered read port.
module pmem_ram #(
    parameter int IW = 12,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    // No reset on the array so it maps onto block RAM.
    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pmem_loader.sv
// Program memory with fetch port and a valid/ready block loader that tracks a running checksum.
module pmem_loader
    import pmem_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          En,
    input  logic [AW-1:0] Addr,
    output logic [IW-1:0] Instr,
    output logic          Instr_Valid,
    input  logic          Load_Start,
    input  logic [AW-1:0] Load_Base,
    input  logic [AW:0]   Load_Count,
    input  logic          Load_Valid,
    input  logic [IW-1:0] Load_Instr,
    output logic          Load_Ready,
    output logic          Load_Busy,
    output logic          Load_Done,
    output logic          Load_Err,
    output logic [IW-1:0] Checksum
);

    localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

    state_t        state_reg, state_next;
    logic [AW-1:0] ptr_reg, ptr_next;
    logic [AW:0]   remaining_reg, remaining_next;
    logic [IW-1:0] checksum_reg, checksum_next;
    logic          err_reg, err_next;
    logic          fetch_valid_reg;
    logic          fetch_en;
    logic          xfer;
    logic [IW-1:0] ram_rdata;

    assign fetch_en = En && (state_reg == IDLE);
    assign xfer     = Load_Valid && (state_reg == LOAD);

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        checksum_next  = checksum_reg;
        err_next       = err_reg;
        case (state_reg)
            IDLE: begin
                if (Load_Start) begin
                    if (Load_Count > DEPTH_CNT) begin
                        err_next = 1'b1;
                    end else begin
                        err_next       = 1'b0;
                        checksum_next  = '0;
                        ptr_next       = Load_Base;
                        remaining_next = Load_Count;
                        state_next     = (Load_Count == '0) ? DONE : LOAD;
                    end
                end
            end
            LOAD: begin
                if (Load_Valid) begin
                    // Pointer wraps naturally at the top of memory.
                    ptr_next       = ptr_reg + 1'b1;
                    checksum_next  = checksum_reg + Load_Instr;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == {{AW{1'b0}}, 1'b1}) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            remaining_reg   <= '0;
            checksum_reg    <= '0;
            err_reg         <= 1'b0;
            fetch_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            remaining_reg   <= remaining_next;
            checksum_reg    <= checksum_next;
            err_reg         <= err_next;
            fetch_valid_reg <= fetch_en;
        end
    end

    pmem_ram #(
        .IW(IW),
        .AW(AW)
    ) u_ram (
        .clk  (clk),
        .we   (xfer),
        .waddr(ptr_reg),
        .wdata(Load_Instr),
        .re   (fetch_en),
        .raddr(Addr),
        .rdata(ram_rdata)
    );

    // RAM read register is unreset; the valid flag gates it to zero.
    assign Instr       = fetch_valid_reg ? ram_rdata : '0;
    assign Instr_Valid = fetch_valid_reg;
    assign Load_Ready  = (state_reg == LOAD);
    assign Load_Busy   = (state_reg != IDLE);
    assign Load_Done   = (state_reg == DONE);
    assign Load_Err    = err_reg;
    assign Checksum    = checksum_reg;

endmodule

// File: tb/tb_pmem_loader.sv
// Randomized scoreboard bench for pmem_loader against an array-based memory model.
module tb_pmem_loader;

    localparam int IW    = 12;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          En          = 1'b0;
    logic [AW-1:0] Addr        = '0;
    logic [IW-1:0] Instr;
    logic          Instr_Valid;
    logic          Load_Start  = 1'b0;
    logic [AW-1:0] Load_Base   = '0;
    logic [AW:0]   Load_Count  = '0;
    logic          Load_Valid  = 1'b0;
    logic [IW-1:0] Load_Instr  = '0;
    logic          Load_Ready;
    logic          Load_Busy;
    logic          Load_Done;
    logic          Load_Err;
    logic [IW-1:0] Checksum;

    logic [IW-1:0] mem_model [DEPTH];
    logic          err_model = 1'b0;
    logic [IW-1:0] fetch_q [$];
    logic [IW-1:0] done_q [$];
    logic [IW-1:0] dir_words [$];
    int            pass_cnt  = 0;
    int            total_cnt = 0;

    pmem_loader #(.IW(IW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .En         (En),
        .Addr       (Addr),
        .Instr      (Instr),
        .Instr_Valid(Instr_Valid),
        .Load_Start (Load_Start),
        .Load_Base  (Load_Base),
        .Load_Count (Load_Count),
        .Load_Valid (Load_Valid),
        .Load_Instr (Load_Instr),
        .Load_Ready (Load_Ready),
        .Load_Busy  (Load_Busy),
        .Load_Done  (Load_Done),
        .Load_Err   (Load_Err),
        .Checksum   (Checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected fetch data and burst checksums as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (Instr_Valid) begin
                if (fetch_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL fetch_unexpected: Instr_Valid=1 Instr=0x%0h, expected no fetch", Instr);
                end else begin
                    check("fetch_data", Instr, fetch_q.pop_front());
                end
            end else begin
                check("instr_zero_when_invalid", Instr, 0);
            end
            if (Load_Done) begin
                if (done_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL done_unexpected: Load_Done=1 Checksum=0x%0h, expected no done", Checksum);
                end else begin
                    $display("burst done: checksum 0x%0h", Checksum);
                    check("done_checksum", Checksum, done_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, Instr, 0);
        check({tag, "_instr_valid"}, Instr_Valid, 0);
        check({tag, "_ready"}, Load_Ready, 0);
        check({tag, "_busy"}, Load_Busy, 0);
        check({tag, "_done"}, Load_Done, 0);
        check({tag, "_err"}, Load_Err, 0);
        check({tag, "_checksum"}, Checksum, 0);
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        En   = 1'b1;
        Addr = a;
        fetch_q.push_back(mem_model[a]);
        $display("fetch addr 0x%02h expect 0x%03h", a, mem_model[a]);
        step();
        En = 1'b0;
    endtask

    // One burst: words come from dir_words when supplied, otherwise random.
    task automatic load(input logic [AW-1:0] base, input int count, input int abort_after,
                        input bit en_during, input int gap_pct);
        logic [IW-1:0] w;
        logic [IW-1:0] sum;
        logic [AW-1:0] a;
        int            n;
        sum = '0;
        n   = 0;
        $display("load base 0x%02h count %0d abort %0d", base, count, abort_after);
        Load_Start = 1'b1;
        Load_Base  = base;
        Load_Count = 9'(count);
        En         = 1'b0;
        if (count > DEPTH) begin
            err_model = 1'b1;
            step();
            Load_Start = 1'b0;
            check("err_set", Load_Err, err_model);
            check("busy_after_err", Load_Busy, 0);
            dir_words.delete();
            return;
        end
        err_model = 1'b0;
        if (count == 0) begin
            done_q.push_back('0);
            step();
            Load_Start = 1'b0;
            check("zero_done_pulse", Load_Done, 1);
            check("zero_ready_low", Load_Ready, 0);
            check("zero_err_clear", Load_Err, err_model);
            step();
            check("zero_busy_cleared", Load_Busy, 0);
            return;
        end
        step();
        Load_Start = 1'b0;
        check("err_cleared_on_start", Load_Err, err_model);
        while (n < count) begin
            if (abort_after >= 0 && n == abort_after) begin
                rst        = 1'b1;
                Load_Valid = 1'b0;
                Load_Start = 1'b0;
                En         = 1'b0;
                step();
                rst = 1'b0;
                check_reset_outputs("abort_reset");
                dir_words.delete();
                return;
            end
            check("ready_in_load", Load_Ready, 1);
            check("busy_in_load", Load_Busy, 1);
            En         = en_during;
            Addr       = 8'($urandom);
            Load_Start = ($urandom_range(0, 4) == 0);
            Load_Base  = 8'($urandom);
            Load_Count = 9'($urandom);
            if ($urandom_range(0, 99) >= gap_pct) begin
                w = (dir_words.size() > 0) ? dir_words.pop_front() : 12'($urandom);
                a = base + 8'(n);
                Load_Valid      = 1'b1;
                Load_Instr      = w;
                mem_model[a]    = w;
                sum             = sum + w;
                n++;
                if (n == count && abort_after < 0) begin
                    done_q.push_back(sum);
                end
            end else begin
                Load_Valid = 1'b0;
                Load_Instr = 12'($urandom);
            end
            step();
        end
        Load_Valid = 1'b0;
        Load_Start = 1'b0;
        En         = 1'b0;
        check("done_pulse", Load_Done, 1);
        check("done_ready_low", Load_Ready, 0);
        check("done_err", Load_Err, err_model);
        step();
        check("busy_cleared", Load_Busy, 0);
        check("done_one_cycle", Load_Done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] b;
        repeat (3) step();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Fill the whole array so every fetch has a known model value.
        load(8'($urandom), DEPTH, -1, 1'b0, 10);

        // Test 1: back-to-back burst at 0x10.
        dir_words = {12'h111, 12'h222, 12'h333};
        load(8'h10, 3, -1, 1'b0, 0);
        fetch(8'h11);
        fetch(8'h10);
        fetch(8'h12);

        // Test 2: wrapping burst with valid gaps.
        dir_words = {12'h001, 12'h002, 12'h003, 12'h004};
        load(8'hFE, 4, -1, 1'b0, 50);
        fetch(8'hFE);
        fetch(8'hFF);
        fetch(8'h00);
        fetch(8'h01);

        // Test 3: empty burst, oversize request, then a clearing start.
        load(8'h40, 0, -1, 1'b0, 0);
        load(8'h40, 257, -1, 1'b0, 0);
        step();
        check("err_sticky", Load_Err, err_model);
        load(8'h40, 2, -1, 1'b0, 0);

        // Test 4: fetch enable and spurious starts during a burst.
        load(8'h80, 8, -1, 1'b1, 30);
        for (int i = 0; i < 8; i++) fetch(8'h80 + 8'(i));

        // Test 5: reset after 2 of 5 words.
        load(8'h60, 5, 2, 1'b1, 0);
        for (int i = 0; i < 5; i++) fetch(8'h60 + 8'(i));

        // Test 6: checksum wrap.
        dir_words = {12'hFFF, 12'h002};
        load(8'h20, 2, -1, 1'b0, 0);

        for (int r = 0; r < 10; r++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                load(b, $urandom_range(257, 511), -1, 1'b0, 0);
            end
            load(b, $urandom_range(1, 20), -1, 1'($urandom), $urandom_range(0, 60));
            for (int i = 0; i < 6; i++) fetch(b + 8'($urandom_range(0, 20)));
            for (int i = 0; i < 4; i++) fetch(8'($urandom));
        end

        repeat (3) step();
        check("fetch_queue_drained", fetch_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
